slice_mac: RTL and testbench



---
 rtl/slice_mac.sv | 108 ++++++++++
 tb/tb_slice_mac.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/slice_mac.sv
// slice_mac: dot product of one buffer_slice window with a coefficient vector.
// One element per cycle through a registered multiplier.
`ifndef DWIDTH_DAT
`define DWIDTH_DAT 8
`endif
`ifndef DWIDTH_SLICE
`define DWIDTH_SLICE 3
`endif

module slice_mac #(
    parameter int DW = `DWIDTH_DAT,
    parameter int CW = `DWIDTH_DAT,
    parameter int N  = `DWIDTH_SLICE,
    parameter int AW = DW + CW + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 start_ready,
    input  logic [DW*N-1:0]      din,
    input  logic [CW*N-1:0]      coef,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic signed [AW-1:0] res_data
);
    localparam int PW = DW + CW;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DRAIN,
        HOLD
    } state_t;

    state_t state, state_d;

    logic        [DW-1:0] d_q [N];
    logic signed [CW-1:0] c_q [N];
    logic [IW-1:0]        idx;
    logic signed [PW-1:0] prod;
    logic                 prod_vld;
    logic signed [AW-1:0] acc;

    logic signed [PW:0]   op_d;
    logic signed [PW:0]   op_c;
    logic signed [PW:0]   mul;
    logic signed [AW-1:0] prod_ext;

    // data is unsigned, so it enters the signed multiply zero-extended
    assign op_d = {{(CW + 1){1'b0}}, d_q[idx]};
    assign op_c = {{(DW + 1){c_q[idx][CW-1]}}, c_q[idx]};
    assign mul  = op_d * op_c;
    assign prod_ext = AW'(prod);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = MUL;
            MUL:     if (idx == LAST) state_d = DRAIN;
            DRAIN:   state_d = HOLD;
            HOLD:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            acc      <= '0;
            prod     <= '0;
            prod_vld <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < N; k++) begin
                            d_q[k] <= din[DW*k +: DW];
                            c_q[k] <= coef[CW*k +: CW];
                        end
                        idx      <= '0;
                        acc      <= '0;
                        prod_vld <= 1'b0;
                    end
                end
                MUL: begin
                    prod     <= mul[PW-1:0];
                    prod_vld <= 1'b1;
                    if (prod_vld) acc <= acc + prod_ext;
                    if (idx != LAST) idx <= idx + IW'(1);
                end
                DRAIN: begin
                    acc      <= acc + prod_ext;
                    prod_vld <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign res_valid   = (state == HOLD);
    assign res_data    = acc;

endmodule

// File: tb/tb_slice_mac.sv
// tb_slice_mac: random and directed checks of slice_mac against a
// plain-arithmetic dot-product model (N=3 and N=1 instances).
module tb_slice_mac;
    localparam int DW  = 8;
    localparam int CW  = 8;
    localparam int N   = 3;
    localparam int AW  = 18;
    localparam int AW1 = 16;

    logic clk = 1'b0;
    logic rst;
    logic start, start_ready;
    logic [DW*N-1:0] din;
    logic [CW*N-1:0] coef;
    logic res_valid, res_ready;
    logic signed [AW-1:0] res_data;

    logic s1_start, s1_start_ready;
    logic [DW-1:0] s1_din;
    logic [CW-1:0] s1_coef;
    logic s1_res_valid, s1_res_ready;
    logic signed [AW1-1:0] s1_res_data;

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    slice_mac #(.DW(DW), .CW(CW), .N(N), .AW(AW)) u_dut (
        .clk(clk), .rst(rst),
        .start(start), .start_ready(start_ready),
        .din(din), .coef(coef),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data)
    );

    slice_mac #(.DW(DW), .CW(CW), .N(1), .AW(AW1)) u_dut1 (
        .clk(clk), .rst(rst),
        .start(s1_start), .start_ready(s1_start_ready),
        .din(s1_din), .coef(s1_coef),
        .res_valid(s1_res_valid), .res_ready(s1_res_ready),
        .res_data(s1_res_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int dot(input int d[N], input int c[N]);
        int s = 0;
        for (int k = 0; k < N; k++) s += d[k] * c[k];
        return s;
    endfunction

    task automatic pack(input int d[N], input int c[N]);
        for (int k = 0; k < N; k++) begin
            din[DW*k +: DW]  = d[k][DW-1:0];
            coef[CW*k +: CW] = c[k][CW-1:0];
        end
    endtask

    task automatic run(input string tag, input int d[N], input int c[N],
                       input int hold, output int t0);
        int exp;
        int w;
        exp = dot(d, c);
        w = 0;
        while (!start_ready && w < 50) begin
            tick();
            w++;
        end
        check({tag, "_idle"}, start_ready, 1);
        pack(d, c);
        start = 1'b1;
        tick();
        t0 = cyc;
        start = 1'b0;
        din = $urandom;
        coef = $urandom;
        res_ready = (hold == 0);
        check({tag, "_busy"}, start_ready, 0);
        repeat (N) begin
            tick();
            check({tag, "_early"}, res_valid, 0);
        end
        tick();
        check({tag, "_valid"}, res_valid, 1);
        check({tag, "_data"}, res_data, exp);
        for (int i = 0; i < hold; i++) begin
            din = $urandom;
            coef = $urandom;
            start = 1'($urandom);
            tick();
            check({tag, "_hvalid"}, res_valid, 1);
            check({tag, "_hdata"}, res_data, exp);
            check({tag, "_hready"}, start_ready, 0);
        end
        start = 1'b0;
        res_ready = 1'b1;
        tick();
        check({tag, "_done"}, start_ready, 1);
        check({tag, "_dvalid"}, res_valid, 0);
    endtask

    initial begin
        int da[N];
        int ca[N];
        int ta, tb;
        rst = 1'b1;
        start = 1'b0;
        res_ready = 1'b0;
        din = '0;
        coef = '0;
        s1_start = 1'b0;
        s1_res_ready = 1'b0;
        s1_din = '0;
        s1_coef = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", start_ready, 1);
        check("rst_valid", res_valid, 0);
        check("rst_data", res_data, 0);
        check("rst1_ready", s1_start_ready, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("idle_ready", start_ready, 1);
        check("idle_valid", res_valid, 0);

        da = '{1, 2, 3};
        ca = '{1, 1, 1};
        res_ready = 1'b1;
        run("basic", da, ca, 0, ta);

        da = '{255, 255, 255};
        ca = '{-1, -1, -1};
        run("neg", da, ca, 0, ta);
        ca = '{127, 127, 127};
        run("pos", da, ca, 0, ta);

        da = '{17, 99, 201};
        ca = '{-7, 33, -128};
        run("bp", da, ca, 10, ta);

        da = '{9, 9, 9};
        ca = '{100, 100, 100};
        pack(da, ca);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_ready", start_ready, 1);
        check("mrst_valid", res_valid, 0);
        check("mrst_data", res_data, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mrst_novalid", res_valid, 0);
        end
        da = '{3, 4, 5};
        ca = '{-2, 6, 1};
        run("fresh", da, ca, 0, ta);

        da = '{4, 5, 6};
        ca = '{2, -3, 1};
        run("b2b_a", da, ca, 0, ta);
        da = '{0, 0, 9};
        ca = '{0, 0, -2};
        run("b2b_b", da, ca, 0, tb);
        check("b2b_interval", tb - ta, N + 3);

        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < N; k++) begin
                da[k] = int'($urandom_range(0, 255));
                ca[k] = int'($urandom_range(0, 255)) - 128;
            end
            run("rand", da, ca, int'($urandom_range(0, 4)), ta);
        end

        s1_din = 8'd200;
        s1_coef = 8'hFB;
        s1_start = 1'b1;
        tick();
        s1_start = 1'b0;
        s1_din = 8'd1;
        s1_coef = 8'd1;
        check("n1_busy", s1_start_ready, 0);
        tick();
        check("n1_early", s1_res_valid, 0);
        tick();
        check("n1_valid", s1_res_valid, 1);
        check("n1_data", s1_res_data, -1000);
        s1_res_ready = 1'b1;
        tick();
        check("n1_done", s1_start_ready, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
